// File: rtl/baseline_pkg.sv
// Shared types and helpers for the multi-channel baseline scheduler.
// The channel finder works on a fixed maximum width so one function serves every NCH.
package baseline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_GAP     = 3'd5
    } sched_state_t;

    localparam int DEF_WIN_LOG2 = 21;
    localparam int DEF_PIPE_LAT = 3;

    localparam int MAX_NCH = 64;
    localparam int MAX_CW  = 6;
    localparam int PTR_W   = MAX_CW + 1;

    typedef struct packed {
        logic              found;
        logic [MAX_CW-1:0] idx;
    } pick_t;

    // Lowest set bit of mask at or above ptr; descending scan so the lowest hit wins.
    function automatic pick_t next_enabled(input logic [MAX_NCH-1:0] mask,
                                           input logic [PTR_W-1:0]   ptr);
        pick_t res;
        res.found = 1'b0;
        res.idx   = {MAX_CW{1'b0}};
        for (int i = MAX_NCH - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= ptr)) begin
                res.found = 1'b1;
                res.idx   = MAX_CW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/baseline_ch_pick.sv
// Combinational priority finder: next enabled channel at or after the sweep pointer.
module baseline_ch_pick
    import baseline_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [CW:0]    ptr_i,
    output logic           found_o,
    output logic [CW-1:0]  idx_o
);

    pick_t pick_s;

    assign pick_s  = next_enabled(MAX_NCH'(mask_i), PTR_W'(ptr_i));
    assign found_o = pick_s.found;
    assign idx_o   = CW'(pick_s.idx);

endmodule

// File: rtl/baseline_sched.sv
// Round-robin sequencer sharing one block-average baseline engine across NCH channels.
// Each channel: select, clear engine, accumulate one window plus pipeline latency, capture.
module baseline_sched
    import baseline_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int WIN_LOG2   = DEF_WIN_LOG2,
    parameter int PIPE_LAT   = DEF_PIPE_LAT,
    parameter int CLR_CYCLES = 2,
    parameter int CW         = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [15:0]        gap_cycles,
    input  logic [NCH-1:0]     ch_mask,
    output logic [CW-1:0]      ch_sel,
    output logic               eng_clear,
    output logic               eng_enable,
    input  logic signed [15:0] eng_y,
    output logic               baseline_valid,
    output logic [CW-1:0]      baseline_ch,
    output logic signed [15:0] baseline_data,
    output logic               busy,
    output logic               sweep_done
);

    localparam int CNT_W = WIN_LOG2 + 2;
    localparam logic [CNT_W-1:0] ACC_LAST =
        CNT_W'((64'd1 << WIN_LOG2) + 64'(PIPE_LAT) - 64'd1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);

    sched_state_t        state_q;
    logic [NCH-1:0]      mask_q;
    logic [CW:0]         ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [15:0]         gap_cnt_q;
    logic [CW-1:0]       ch_sel_q;
    logic                eng_clear_q;
    logic                eng_enable_q;
    logic                baseline_valid_q;
    logic [CW-1:0]       baseline_ch_q;
    logic signed [15:0]  baseline_data_q;
    logic                busy_q;
    logic                sweep_done_q;

    logic                pick_found_s;
    logic [CW-1:0]       pick_idx_s;

    baseline_ch_pick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_pick (
        .mask_i  (mask_q),
        .ptr_i   (ptr_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    // Scheduler FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            mask_q           <= {NCH{1'b0}};
            ptr_q            <= {(CW+1){1'b0}};
            cnt_q            <= {CNT_W{1'b0}};
            gap_cnt_q        <= 16'd0;
            ch_sel_q         <= {CW{1'b0}};
            eng_clear_q      <= 1'b0;
            eng_enable_q     <= 1'b0;
            baseline_valid_q <= 1'b0;
            baseline_ch_q    <= {CW{1'b0}};
            baseline_data_q  <= 16'sd0;
            busy_q           <= 1'b0;
            sweep_done_q     <= 1'b0;
        end else begin
            baseline_valid_q <= 1'b0;
            sweep_done_q     <= 1'b0;
            if (stop && (state_q != ST_IDLE)) begin
                // Abort: one-cycle engine clear, and the interrupted window is never published.
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                eng_enable_q <= 1'b0;
                eng_clear_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        eng_clear_q  <= 1'b0;
                        eng_enable_q <= 1'b0;
                        if (start && !stop) begin
                            if (ch_mask == {NCH{1'b0}}) begin
                                sweep_done_q <= 1'b1;
                            end else begin
                                mask_q  <= ch_mask;
                                ptr_q   <= {(CW+1){1'b0}};
                                busy_q  <= 1'b1;
                                state_q <= ST_SELECT;
                            end
                        end
                    end
                    ST_SELECT: begin
                        if (pick_found_s) begin
                            ch_sel_q    <= pick_idx_s;
                            ptr_q       <= {1'b0, pick_idx_s} + {{CW{1'b0}}, 1'b1};
                            cnt_q       <= {CNT_W{1'b0}};
                            eng_clear_q <= 1'b1;
                            state_q     <= ST_CLEAR;
                        end else begin
                            sweep_done_q <= 1'b1;
                            if (continuous) begin
                                gap_cnt_q <= gap_cycles;
                                state_q   <= ST_GAP;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        if (cnt_q == CLR_LAST) begin
                            cnt_q        <= {CNT_W{1'b0}};
                            eng_clear_q  <= 1'b0;
                            eng_enable_q <= 1'b1;
                            state_q      <= ST_ACCUM;
                        end else begin
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_ACCUM: begin
                        if (cnt_q == ACC_LAST) begin
                            eng_enable_q <= 1'b0;
                            state_q      <= ST_CAPTURE;
                        end else begin
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_CAPTURE: begin
                        baseline_data_q  <= eng_y;
                        baseline_ch_q    <= ch_sel_q;
                        baseline_valid_q <= 1'b1;
                        state_q          <= ST_SELECT;
                    end
                    ST_GAP: begin
                        if (!continuous) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (gap_cnt_q == 16'd0) begin
                            mask_q  <= ch_mask;
                            ptr_q   <= {(CW+1){1'b0}};
                            state_q <= ST_SELECT;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 16'd1;
                        end
                    end
                    default: begin
                        busy_q       <= 1'b0;
                        eng_clear_q  <= 1'b0;
                        eng_enable_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ch_sel         = ch_sel_q;
    assign eng_clear      = eng_clear_q;
    assign eng_enable     = eng_enable_q;
    assign baseline_valid = baseline_valid_q;
    assign baseline_ch    = baseline_ch_q;
    assign baseline_data  = baseline_data_q;
    assign busy           = busy_q;
    assign sweep_done     = sweep_done_q;

endmodule

// File: tb/tb_baseline_sched.sv
// Bench for baseline_sched: a counting engine stand-in drives eng_y, and expected strobe
// lists/timings are derived from the channel mask and the per-channel period arithmetic.
module tb_baseline_sched;

    localparam int NCH    = 4;
    localparam int WIN    = 4;
    localparam int PIPE   = 3;
    localparam int CLR    = 2;
    localparam int ACC_N  = (1 << WIN) + PIPE;
    localparam int PERIOD = 1 + CLR + ACC_N + 1;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [15:0]        gap_cycles;
    logic [3:0]         ch_mask;
    logic [1:0]         ch_sel;
    logic               eng_clear;
    logic               eng_enable;
    logic signed [15:0] eng_y;
    logic               baseline_valid;
    logic [1:0]         baseline_ch;
    logic signed [15:0] baseline_data;
    logic               busy;
    logic               sweep_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic signed [15:0] ch_val [NCH];
    logic signed [15:0] en_cnt;
    bit                 eng_mode;

    int                 obs_ch[$];
    logic signed [15:0] obs_data[$];
    int                 obs_t[$];
    int                 done_t[$];
    bit                 busy_seen;

    baseline_sched #(
        .NCH        (NCH),
        .WIN_LOG2   (WIN),
        .PIPE_LAT   (PIPE),
        .CLR_CYCLES (CLR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .continuous     (continuous),
        .gap_cycles     (gap_cycles),
        .ch_mask        (ch_mask),
        .ch_sel         (ch_sel),
        .eng_clear      (eng_clear),
        .eng_enable     (eng_enable),
        .eng_y          (eng_y),
        .baseline_valid (baseline_valid),
        .baseline_ch    (baseline_ch),
        .baseline_data  (baseline_data),
        .busy           (busy),
        .sweep_done     (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine stand-in: counts enabled cycles since the last clear, offset by a per-channel level.
    always @(posedge clk) begin
        if (eng_clear) en_cnt <= 16'sd0;
        else if (eng_enable) en_cnt <= en_cnt + 16'sd1;
    end
    assign eng_y = ch_val[ch_sel] + (eng_mode ? en_cnt : 16'sd0);

    always @(negedge clk) begin
        if (reset) begin
            if (baseline_valid) begin
                obs_ch.push_back(int'(baseline_ch));
                obs_data.push_back(baseline_data);
                obs_t.push_back(cyc);
            end
            if (sweep_done) done_t.push_back(cyc);
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic clear_obs();
        obs_ch.delete();
        obs_data.delete();
        obs_t.delete();
        done_t.delete();
        busy_seen = 1'b0;
    endtask

    task automatic kick(input logic [3:0] m, output int t0);
        @(negedge clk);
        ch_mask = m;
        start   = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ch_sel !== 2'd0) begin n_bad++; $display("FAIL reset_ch_sel got %0d want 0", ch_sel); end
        n_cmp++; if (eng_clear !== 1'b0) begin n_bad++; $display("FAIL reset_eng_clear got %0b want 0", eng_clear); end
        n_cmp++; if (eng_enable !== 1'b0) begin n_bad++; $display("FAIL reset_eng_enable got %0b want 0", eng_enable); end
        n_cmp++; if (baseline_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", baseline_valid); end
        n_cmp++; if (baseline_data !== 16'sd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", baseline_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (sweep_done !== 1'b0) begin n_bad++; $display("FAIL reset_sweep_done got %0b want 0", sweep_done); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sweep(input logic [3:0] m, input bit cmode, input string name);
        int t0;
        int exp_ch[$];
        logic signed [15:0] e;
        eng_mode = cmode;
        clear_obs();
        kick(m, t0);
        ch_mask = 4'($urandom);
        for (int i = 0; i < NCH; i++) if (m[i]) exp_ch.push_back(i);
        repeat (PERIOD * exp_ch.size() + 10) @(negedge clk);
        n_cmp++;
        if (obs_ch.size() != exp_ch.size()) begin
            n_bad++; $display("FAIL %s_strobe_count got %0d want %0d", name, obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            e = ch_val[exp_ch[k]] + (cmode ? 16'(ACC_N) : 16'sd0);
            n_cmp++; if (obs_ch[k] != exp_ch[k]) begin n_bad++; $display("FAIL %s_ch[%0d] got %0d want %0d", name, k, obs_ch[k], exp_ch[k]); end
            n_cmp++; if (obs_data[k] !== e) begin n_bad++; $display("FAIL %s_data[%0d] got %0d want %0d", name, k, obs_data[k], e); end
            n_cmp++; if (obs_t[k] != t0 + PERIOD * (k + 1)) begin n_bad++; $display("FAIL %s_time[%0d] got %0d want %0d", name, k, obs_t[k] - t0, PERIOD * (k + 1)); end
        end
        n_cmp++;
        if (done_t.size() != 1) begin
            n_bad++; $display("FAIL %s_done_count got %0d want 1", name, done_t.size());
        end else begin
            n_cmp++;
            if (done_t[0] != t0 + PERIOD * exp_ch.size() + (exp_ch.size() > 0 ? 1 : 0)) begin
                n_bad++; $display("FAIL %s_done_time got %0d want %0d", name, done_t[0] - t0,
                                  PERIOD * exp_ch.size() + (exp_ch.size() > 0 ? 1 : 0));
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_after got %0b want 0", name, busy); end
        if (exp_ch.size() == 0) begin
            n_cmp++; if (busy_seen) begin n_bad++; $display("FAIL %s_busy_rose got 1 want 0", name); end
        end
    endtask

    task automatic test_stop();
        int t0;
        eng_mode = 1'b1;
        clear_obs();
        kick(4'b1011, t0);
        wait_cyc(t0 + PERIOD + 1 + CLR + 10);
        n_cmp++; if (eng_enable !== 1'b1) begin n_bad++; $display("FAIL stop_pre_enable got %0b want 1", eng_enable); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy got %0b want 0", busy); end
        n_cmp++; if (eng_clear !== 1'b1) begin n_bad++; $display("FAIL stop_clear got %0b want 1", eng_clear); end
        n_cmp++; if (eng_enable !== 1'b0) begin n_bad++; $display("FAIL stop_enable got %0b want 0", eng_enable); end
        @(negedge clk);
        n_cmp++; if (eng_clear !== 1'b0) begin n_bad++; $display("FAIL stop_clear_len got %0b want 0", eng_clear); end
        repeat (2 * PERIOD) @(negedge clk);
        n_cmp++; if (obs_ch.size() != 1) begin n_bad++; $display("FAIL stop_strobes got %0d want 1", obs_ch.size()); end
        n_cmp++; if (obs_ch.size() > 0 && obs_ch[0] != 0) begin n_bad++; $display("FAIL stop_first_ch got %0d want 0", obs_ch[0]); end
        n_cmp++; if (done_t.size() != 0) begin n_bad++; $display("FAIL stop_done got %0d want 0", done_t.size()); end
        test_sweep(4'b1011, 1'b1, "restart");
    endtask

    task automatic test_async_reset();
        int t0;
        eng_mode = 1'b1;
        clear_obs();
        kick(4'b1000, t0);
        @(negedge clk);
        n_cmp++; if (ch_sel !== 2'd3 || eng_clear !== 1'b1) begin n_bad++; $display("FAIL areset_pre got sel=%0d clr=%0b want sel=3 clr=1", ch_sel, eng_clear); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (ch_sel !== 2'd0) begin n_bad++; $display("FAIL areset_ch_sel got %0d want 0", ch_sel); end
        n_cmp++; if (eng_clear !== 1'b0) begin n_bad++; $display("FAIL areset_clear got %0b want 0", eng_clear); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy got %0b want 0", busy); end
        n_cmp++; if (baseline_data !== 16'sd0 || baseline_ch !== 2'd0) begin n_bad++; $display("FAIL areset_bl got %0d/%0d want 0/0", baseline_data, baseline_ch); end
        n_cmp++; if (eng_enable !== 1'b0 || baseline_valid !== 1'b0 || sweep_done !== 1'b0) begin n_bad++; $display("FAIL areset_strobes got %0b%0b%0b want 000", eng_enable, baseline_valid, sweep_done); end
        @(negedge clk);
        reset = 1'b1;
        clear_obs();
        repeat (2 * PERIOD) @(negedge clk);
        n_cmp++; if (obs_ch.size() != 0 || done_t.size() != 0) begin n_bad++; $display("FAIL areset_after got %0d strobes %0d done want 0", obs_ch.size(), done_t.size()); end
        n_cmp++; if (busy_seen) begin n_bad++; $display("FAIL areset_busy_after got 1 want 0"); end
    endtask

    task automatic test_continuous(input int gap, input int a, input int b);
        int t0, p2, s1, s2, s3;
        int exp_ch[3];
        gap_cycles = 16'(gap);
        continuous = 1'b1;
        eng_mode   = 1'b1;
        clear_obs();
        kick(4'(1 << a), t0);
        p2 = PERIOD + 2 + gap;
        s1 = t0 + PERIOD;
        s2 = s1 + p2;
        s3 = s2 + p2;
        exp_ch[0] = a; exp_ch[1] = a; exp_ch[2] = b;
        wait_cyc(s2 + 1);
        ch_mask = 4'(1 << b);
        wait_cyc(s3 + 1);
        continuous = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_g%0d_stop_busy got %0b want 0", gap, busy); end
        repeat (2 * PERIOD) @(negedge clk);
        n_cmp++; if (obs_ch.size() != 3) begin n_bad++; $display("FAIL cont_g%0d_strobes got %0d want 3", gap, obs_ch.size()); end
        for (int k = 0; k < 3 && k < obs_ch.size(); k++) begin
            n_cmp++; if (obs_ch[k] != exp_ch[k]) begin n_bad++; $display("FAIL cont_g%0d_ch[%0d] got %0d want %0d", gap, k, obs_ch[k], exp_ch[k]); end
            n_cmp++; if (obs_t[k] != s1 + k * p2) begin n_bad++; $display("FAIL cont_g%0d_time[%0d] got %0d want %0d", gap, k, obs_t[k] - t0, s1 + k * p2 - t0); end
            n_cmp++; if (obs_data[k] !== ch_val[exp_ch[k]] + 16'(ACC_N)) begin n_bad++; $display("FAIL cont_g%0d_data[%0d] got %0d want %0d", gap, k, obs_data[k], ch_val[exp_ch[k]] + 16'(ACC_N)); end
        end
        n_cmp++; if (done_t.size() != 3) begin n_bad++; $display("FAIL cont_g%0d_done_count got %0d want 3", gap, done_t.size()); end
        for (int k = 0; k < 3 && k < done_t.size(); k++) begin
            n_cmp++; if (done_t[k] != s1 + k * p2 + 1) begin n_bad++; $display("FAIL cont_g%0d_done_time[%0d] got %0d want %0d", gap, k, done_t[k] - t0, s1 + k * p2 + 1 - t0); end
        end
    endtask

    task automatic test_start_stop_idle();
        clear_obs();
        @(negedge clk);
        ch_mask = 4'hF;
        start   = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (PERIOD + 5) @(negedge clk);
        n_cmp++; if (busy_seen) begin n_bad++; $display("FAIL startstop_busy got 1 want 0"); end
        n_cmp++; if (obs_ch.size() != 0 || done_t.size() != 0) begin n_bad++; $display("FAIL startstop_activity got %0d strobes %0d done want 0", obs_ch.size(), done_t.size()); end
        n_cmp++; if (eng_clear !== 1'b0 || eng_enable !== 1'b0) begin n_bad++; $display("FAIL startstop_engine got clr=%0b en=%0b want 0/0", eng_clear, eng_enable); end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        gap_cycles = 16'd0;
        ch_mask    = 4'd0;
        eng_mode   = 1'b0;
        for (int i = 0; i < NCH; i++) ch_val[i] = 16'(100 * i);

        test_reset();
        test_sweep(4'b1011, 1'b0, "plan");
        test_sweep(4'b0000, 1'b1, "empty");
        for (int i = 0; i < NCH; i++) ch_val[i] = 16'($urandom);
        for (int r = 0; r < 6; r++) test_sweep(4'($urandom_range(1, 15)), 1'b1, "rand");
        test_stop();
        test_async_reset();
        test_continuous(5, 0, 1);
        test_continuous(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        test_continuous(int'($urandom_range(1, 9)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        test_start_stop_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/baseline_sched.md
Name: baseline_sched

Overview:
- Sequences one shared block-average baseline engine across NCH ADC channels, one channel at a time, in round-robin order.
- For each channel: selects the channel mux, clears the engine, waits one full averaging window plus the engine's pipeline latency, then captures the result.
- Publishes each captured baseline as a one-cycle strobe with its channel tag.
- Sits between the channel input mux and the downstream per-channel baseline-subtraction registers.

Parameters:
- NCH, 8: number of channels; must be ≥2.
- WIN_LOG2, 21: log2 of the engine averaging window in samples.
- PIPE_LAT, 3: cycles from the end of the window until the engine output is stable.
- CLR_CYCLES, 2: cycles eng_clear is held; covers the engine's registered reset.
- CW, $clog2(NCH): channel index width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  pulse; begins a sweep when idle
- stop  in  1  pulse; aborts the current sweep
- continuous  in  1  1 = repeat sweeps after gap_cycles; 0 = single sweep
- gap_cycles  in  16  idle cycles between sweeps in continuous mode
- ch_mask  in  NCH  1 = channel included in the sweep
- ch_sel  out  CW  channel mux select driving the engine input
- eng_clear  out  1  engine reset request
- eng_enable  out  1  engine output enable
- eng_y  in  16 signed  engine baseline output
- baseline_valid  out  1  one-cycle strobe
- baseline_ch  out  CW  channel of the current strobe
- baseline_data  out  16 signed  captured baseline
- busy  out  1  high in any state other than IDLE
- sweep_done  out  1  one-cycle strobe at the end of each sweep

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, counters 0. Takes effect immediately mid-operation; no strobes are produced for the interrupted window.
- States: IDLE, SELECT, CLEAR, ACCUM, CAPTURE, GAP.
- IDLE:
  - start=1 latches ch_mask into mask_q, sets ptr=0, goes to SELECT.
  - start=1 with ch_mask=0: sweep_done pulses and state stays IDLE.
  - start while busy is ignored.
- SELECT (1 cycle):
  - Finds the lowest enabled index ≥ptr in mask_q.
  - Found: ch_sel<=idx, ptr<=idx+1, go to CLEAR.
  - None found: sweep_done pulses, go to GAP if continuous=1, else IDLE.
- CLEAR: eng_clear=1, eng_enable=0 for exactly CLR_CYCLES cycles, then ACCUM.
- ACCUM: eng_clear=0, eng_enable=1 for exactly 2^WIN_LOG2+PIPE_LAT cycles, then CAPTURE. The window counter is WIN_LOG2+2 bits wide and must not wrap.
- CAPTURE (1 cycle): baseline_data<=eng_y, baseline_ch<=ch_sel, baseline_valid<=1 (visible on the next cycle for exactly 1 cycle), then SELECT.
- Per-channel period: 1+CLR_CYCLES+2^WIN_LOG2+PIPE_LAT+1 cycles.
- GAP:
  - Counts gap_cycles (sampled on entry); then re-latches ch_mask, ptr=0, goes to SELECT.
  - gap_cycles=0 means zero idle cycles (GAP lasts 1 cycle).
  - Clearing continuous during GAP ends the run: return to IDLE.
- stop=1 in any non-IDLE state: go to IDLE next cycle, eng_enable=0, eng_clear=1 for one cycle, no baseline_valid, no sweep_done. stop has priority over start and over a simultaneous CAPTURE.
- Changing ch_mask mid-sweep has no effect until the next sweep latch.
- ch_sel holds its value outside CLEAR/ACCUM; it is 0 after reset.
- All outputs are registered.

Decomposition:
- Shared package baseline_pkg holds:
  - state typedef sched_state_t.
  - constants DEF_WIN_LOG2=21 and DEF_PIPE_LAT=3.
  - function next_enabled(mask, ptr), returning {found, idx}.
- One natural sub-module: baseline_ch_pick, a combinational priority finder wrapping next_enabled. Everything else stays in a single FSM module.

Test Plan:
- NCH=4, WIN_LOG2=4, PIPE_LAT=3, CLR_CYCLES=2, mask=4'b1011, single sweep, eng_y=100*ch_sel -> strobes (ch0,0), (ch1,100), (ch3,300) spaced 23 cycles apart; sweep_done 1 cycle after the last strobe; busy then 0.
- start with mask=0 -> sweep_done pulses once, busy never rises, no strobes.
- stop asserted at ACCUM cycle 10 of ch1 -> IDLE next cycle, eng_clear pulses once, no strobe for ch1; a new start restarts at ch0.
- reset=0 asserted mid-CLEAR -> all outputs 0 in the same cycle (asynchronous); after release the block stays IDLE until start.
- continuous=1, gap_cycles=5, mask=4'b0001 -> ch0 strobe repeats with period 23+1(SELECT)+5(GAP)+1 cycles; mask changed to 4'b0010 during GAP -> next strobe is ch1.
- start and stop in the same cycle while IDLE -> remains IDLE, no activity.
